issue_ctrl: RTL and testbench

- Decode-stage pipeline controller for the RV32I core.
- Tracks in-flight register writers in EX, MEM and WB with a 3-slot scoreboard shift register.
- Sequences instruction issue from ID into EX: load-use stalls, branch-redirect flushes, memory-busy freezes, forwarding selects.
- Sits beside the decode block and consumes its rs1/rs2/rd/reg_write outputs. Decode zeroes unused source fields, so source address 0 means "not used".

---
 rtl/issue_pkg.sv | 25 ++
 rtl/sb_match.sv | 12 +
 rtl/issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and constants for the decode-stage issue controller.
package issue_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       load;
  } sb_slot_t;

  // The EX-slot producer moves to MEM as the consumer enters EX, hence FWD_MEM.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit) begin
      return FWD_MEM;
    end else if (mem_hit) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Scoreboard slot lookup: hit when the slot will write a non-zero register equal to addr_i.
module sb_match
  import issue_pkg::*;
(
  input  sb_slot_t   slot_i,
  input  logic [4:0] addr_i,
  output logic       hit_o
);

  assign hit_o = slot_i.valid & slot_i.wen & (slot_i.rd == addr_i) & (addr_i != 5'd0);

endmodule

// File: rtl/issue_ctrl.sv
// Decode-stage issue controller: EX/MEM/WB scoreboard, stalls, flushes and forwarding selects.
// Define ISSUE_CTRL_FWD_EN to enable EX forwarding and the ID-stage WB bypass.
module issue_ctrl
  import issue_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [4:0]       i_rs1_raddr,
  input  logic [4:0]       i_rs2_raddr,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_reg_write,
  input  logic             i_id_is_load,
  input  logic             i_ex_redirect,
  input  logic             i_mem_busy,
  output logic             o_issue,
  output logic             o_if_stall,
  output logic             o_id_flush,
  output logic [1:0]       o_fwd_rs1,
  output logic [1:0]       o_fwd_rs2,
  output logic             o_id_byp_rs1,
  output logic             o_id_byp_rs2,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // Slot 0 = EX, 1 = MEM, 2 = WB.
  sb_slot_t         sb_q [3];
  sb_slot_t         sb_d [3];
  logic [2:0]       hit_rs1;
  logic [2:0]       hit_rs2;
  logic             hazard;
  logic             issue;
  logic             if_stall;
  logic             id_flush;
  logic             stall_cycle;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  for (genvar g = 0; g < 3; g++) begin : g_match
    sb_match u_match_rs1 (
      .slot_i (sb_q[g]),
      .addr_i (i_rs1_raddr),
      .hit_o  (hit_rs1[g])
    );
    sb_match u_match_rs2 (
      .slot_i (sb_q[g]),
      .addr_i (i_rs2_raddr),
      .hit_o  (hit_rs2[g])
    );
  end

`ifdef ISSUE_CTRL_FWD_EN
  assign hazard = sb_q[0].load & (hit_rs1[0] | hit_rs2[0]);
`else
  // Without forwarding, any in-flight writer of a source blocks issue until it retires.
  assign hazard = |{hit_rs1, hit_rs2};
`endif

  // Outputs held low while in reset so nothing issues from a half-reset pipeline.
  always_comb begin
    issue       = 1'b0;
    if_stall    = 1'b0;
    id_flush    = 1'b0;
    stall_cycle = 1'b0;
    if (!i_rst_n) begin
      issue = 1'b0;
    end else if (i_mem_busy) begin
      if_stall = 1'b1;
    end else if (i_ex_redirect) begin
      id_flush = 1'b1;
    end else if (i_id_valid && hazard) begin
      if_stall    = 1'b1;
      stall_cycle = 1'b1;
    end else begin
      issue = i_id_valid;
    end
  end

  assign o_issue    = issue;
  assign o_if_stall = if_stall;
  assign o_id_flush = id_flush;

  always_comb begin
    sb_d = sb_q;
    if (!i_mem_busy) begin
      sb_d[2] = sb_q[1];
      sb_d[1] = sb_q[0];
      sb_d[0] = '0;
      if (issue) begin
        sb_d[0] = '{valid: 1'b1, rd: i_id_rd, wen: i_id_reg_write, load: i_id_is_load};
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_cycle && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sb_q  <= '{default: '0};
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_stall_cnt = cnt_q;

`ifdef ISSUE_CTRL_FWD_EN
  logic [1:0] fwd_rs1_q;
  logic [1:0] fwd_rs1_d;
  logic [1:0] fwd_rs2_q;
  logic [1:0] fwd_rs2_d;

  always_comb begin
    fwd_rs1_d = fwd_rs1_q;
    fwd_rs2_d = fwd_rs2_q;
    if (!i_mem_busy) begin
      fwd_rs1_d = issue ? fwd_sel(hit_rs1[0], hit_rs1[1]) : FWD_RF;
      fwd_rs2_d = issue ? fwd_sel(hit_rs2[0], hit_rs2[1]) : FWD_RF;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fwd_rs1_q <= FWD_RF;
      fwd_rs2_q <= FWD_RF;
    end else begin
      fwd_rs1_q <= fwd_rs1_d;
      fwd_rs2_q <= fwd_rs2_d;
    end
  end

  assign o_fwd_rs1    = fwd_rs1_q;
  assign o_fwd_rs2    = fwd_rs2_q;
  assign o_id_byp_rs1 = hit_rs1[2] & ~hit_rs1[1] & ~hit_rs1[0];
  assign o_id_byp_rs2 = hit_rs2[2] & ~hit_rs2[1] & ~hit_rs2[0];
`else
  assign o_fwd_rs1    = FWD_RF;
  assign o_fwd_rs2    = FWD_RF;
  assign o_id_byp_rs1 = 1'b0;
  assign o_id_byp_rs2 = 1'b0;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl; expectations follow ISSUE_CTRL_FWD_EN if defined.
module tb_issue_ctrl;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [4:0]    rd;
  logic          we;
  logic          ld;
  logic          redirect;
  logic          busy;
  logic          issue;
  logic          if_stall;
  logic          id_flush;
  logic [1:0]    fwd1;
  logic [1:0]    fwd2;
  logic          byp1;
  logic          byp2;
  logic [CW-1:0] cnt;

  int unsigned   n_checks = 0;
  int unsigned   n_bad = 0;
  logic [31:0]   exp_cnt;

  issue_ctrl #(
    .CNT_W (CW)
  ) u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_id_valid     (id_valid),
    .i_rs1_raddr    (rs1),
    .i_rs2_raddr    (rs2),
    .i_id_rd        (rd),
    .i_id_reg_write (we),
    .i_id_is_load   (ld),
    .i_ex_redirect  (redirect),
    .i_mem_busy     (busy),
    .o_issue        (issue),
    .o_if_stall     (if_stall),
    .o_id_flush     (id_flush),
    .o_fwd_rs1      (fwd1),
    .o_fwd_rs2      (fwd2),
    .o_id_byp_rs1   (byp1),
    .o_id_byp_rs2   (byp2),
    .o_stall_cnt    (cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic e_iss, input logic e_stl, input logic e_fl);
    check_eq({tag, ".issue"}, {31'd0, issue}, {31'd0, e_iss});
    check_eq({tag, ".stall"}, {31'd0, if_stall}, {31'd0, e_stl});
    check_eq({tag, ".flush"}, {31'd0, id_flush}, {31'd0, e_fl});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic w, input logic l);
    id_valid = v;
    rs1      = a1;
    rs2      = a2;
    rd       = d;
    we       = w;
    ld       = l;
    #1;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    redirect = 1'b0;
    busy     = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    rst_n = 1'b0;
    redirect = 1'b0;
    busy = 1'b0;
    exp_cnt = 0;
    drive(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0);
    #2;
    ctl("rst", 1'b0, 1'b0, 1'b0);
    check_eq("rst.fwd1", {30'd0, fwd1}, 32'd0);
    check_eq("rst.fwd2", {30'd0, fwd2}, 32'd0);
    check_eq("rst.byp1", {31'd0, byp1}, 32'd0);
    check_eq("rst.cnt", {16'd0, cnt}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // add x5 ; add x6,x5,x1
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    ctl("t1.prod", 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
`ifdef ISSUE_CTRL_FWD_EN
    ctl("t1.cons", 1'b1, 1'b0, 1'b0);
    step();
    id_valid = 1'b0;
    check_eq("t1.fwd1", {30'd0, fwd1}, 32'd1);
    check_eq("t1.fwd2", {30'd0, fwd2}, 32'd0);
`else
    for (int i = 0; i < 3; i++) begin
      ctl("t1.stall", 1'b0, 1'b1, 1'b0);
      step();
    end
    exp_cnt = exp_cnt + 3;
    ctl("t1.go", 1'b1, 1'b0, 1'b0);
    step();
    id_valid = 1'b0;
    check_eq("t1.fwd1", {30'd0, fwd1}, 32'd0);
`endif
    check_eq("t1.cnt", {16'd0, cnt}, exp_cnt);
    idle(3);

    // lw x7 ; add x8,x7,x7
    drive(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1);
    ctl("t2.lw", 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0);
    ctl("t2.lu", 1'b0, 1'b1, 1'b0);
    step();
    exp_cnt = exp_cnt + 1;
`ifdef ISSUE_CTRL_FWD_EN
    ctl("t2.go", 1'b1, 1'b0, 1'b0);
    step();
    id_valid = 1'b0;
    check_eq("t2.fwd1", {30'd0, fwd1}, 32'd2);
    check_eq("t2.fwd2", {30'd0, fwd2}, 32'd2);
`else
    for (int i = 0; i < 2; i++) begin
      ctl("t2.stall", 1'b0, 1'b1, 1'b0);
      step();
    end
    exp_cnt = exp_cnt + 2;
    ctl("t2.go", 1'b1, 1'b0, 1'b0);
    step();
    id_valid = 1'b0;
    check_eq("t2.fwd1", {30'd0, fwd1}, 32'd0);
`endif
    check_eq("t2.cnt", {16'd0, cnt}, exp_cnt);
    idle(3);

    // writer x9, two unrelated, reader of x9
    drive(1'b1, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd2, 5'd0, 5'd11, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd9, 5'd3, 5'd12, 1'b1, 1'b0);
`ifdef ISSUE_CTRL_FWD_EN
    ctl("t3.go", 1'b1, 1'b0, 1'b0);
    check_eq("t3.byp1", {31'd0, byp1}, 32'd1);
    check_eq("t3.byp2", {31'd0, byp2}, 32'd0);
    step();
`else
    ctl("t3.stall", 1'b0, 1'b1, 1'b0);
    check_eq("t3.byp1", {31'd0, byp1}, 32'd0);
    step();
    exp_cnt = exp_cnt + 1;
    ctl("t3.go", 1'b1, 1'b0, 1'b0);
    step();
`endif
    id_valid = 1'b0;
    check_eq("t3.fwd1", {30'd0, fwd1}, 32'd0);
    check_eq("t3.cnt", {16'd0, cnt}, exp_cnt);
    idle(3);

    // load to x0, then reader of x0
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
    ctl("t4.go", 1'b1, 1'b0, 1'b0);
    step();
    id_valid = 1'b0;
    check_eq("t4.fwd1", {30'd0, fwd1}, 32'd0);
    check_eq("t4.fwd2", {30'd0, fwd2}, 32'd0);
    check_eq("t4.cnt", {16'd0, cnt}, exp_cnt);
    idle(3);

    // load-use coinciding with redirect, then 4 busy cycles
    drive(1'b1, 5'd2, 5'd0, 5'd12, 1'b1, 1'b1);
    step();
    redirect = 1'b1;
    drive(1'b1, 5'd12, 5'd0, 5'd14, 1'b1, 1'b0);
    ctl("t5.redir", 1'b0, 1'b0, 1'b1);
    step();
    check_eq("t5.cnt_redir", {16'd0, cnt}, exp_cnt);
    busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      redirect = (i == 2);
      #1;
      ctl("t5.busy", 1'b0, 1'b1, 1'b0);
      step();
    end
    check_eq("t5.cnt_busy", {16'd0, cnt}, exp_cnt);
    busy = 1'b0;
    redirect = 1'b0;
    #1;
`ifdef ISSUE_CTRL_FWD_EN
    ctl("t5.go", 1'b1, 1'b0, 1'b0);
    step();
    id_valid = 1'b0;
    check_eq("t5.fwd1", {30'd0, fwd1}, 32'd2);
`else
    for (int i = 0; i < 2; i++) begin
      ctl("t5.stall", 1'b0, 1'b1, 1'b0);
      step();
    end
    exp_cnt = exp_cnt + 2;
    ctl("t5.go", 1'b1, 1'b0, 1'b0);
    step();
    id_valid = 1'b0;
`endif
    check_eq("t5.cnt", {16'd0, cnt}, exp_cnt);
    idle(3);

    // async reset in the middle of a load-use stall
    drive(1'b1, 5'd2, 5'd0, 5'd13, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd13, 5'd0, 5'd15, 1'b1, 1'b0);
    ctl("t6.stall", 1'b0, 1'b1, 1'b0);
    check_eq("t6.cnt_pre", {16'd0, cnt}, exp_cnt);
    #2;
    rst_n = 1'b0;
    #1;
    ctl("t6.rst", 1'b0, 1'b0, 1'b0);
    check_eq("t6.cnt_rst", {16'd0, cnt}, 32'd0);
    check_eq("t6.fwd1_rst", {30'd0, fwd1}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    ctl("t6.go", 1'b1, 1'b0, 1'b0);
    step();
    id_valid = 1'b0;
    check_eq("t6.fwd1", {30'd0, fwd1}, 32'd0);
    check_eq("t6.cnt", {16'd0, cnt}, 32'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
